// File: rtl/cavlc_decoding_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : cavlc_decoding_ctrl_pkg                                        |
// | Brief    : State codes and helpers for the CAVLC residual sequencing FSM  |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

package cavlc_decoding_ctrl_pkg;

    localparam int CAVLC_STATE_W = 4;

    // Codes are shared with the bit-length mux, so the values are fixed.
    typedef enum logic [CAVLC_STATE_W-1:0] {
        ST_IDLE         = 4'd0,
        ST_NC_T1_LUT    = 4'd1,
        ST_T1_SIGN      = 4'd2,
        ST_LEVEL_PREFIX = 4'd3,
        ST_LEVEL_SUFFIX = 4'd4,
        ST_TZ_LUT       = 4'd5,
        ST_RB_LUT       = 4'd6,
        ST_RUN_ZEROS    = 4'd7,
        ST_DONE         = 4'd8
    } cavlc_state_e;

    function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cavlc_decoding_ctrl.sv
// ----------------------------------------------------------------------------
// | Module   : cavlc_decoding_ctrl                                            |
// | Brief    : Sequencer for one CAVLC residual block plus its counters       |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module cavlc_decoding_ctrl
    import cavlc_decoding_ctrl_pkg::*;
#(
    parameter int STATE_W   = 4,
    parameter int MAX_COEFF = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cavlc_start,
    input  logic [4:0]         maxNumCoeff,
    input  logic               bs_ready,
    input  logic [4:0]         TotalCoeff_lut,
    input  logic [1:0]         TrailingOnes_lut,
    input  logic [3:0]         total_zeros_lut,
    input  logic [3:0]         run_before_lut,
    output logic [STATE_W-1:0] cavlc_decoder_state,
    output logic [4:0]         TotalCoeff,
    output logic [1:0]         TrailingOnes,
    output logic [3:0]         i_level,
    output logic [3:0]         i_run,
    output logic [3:0]         zerosLeft,
    output logic               cavlc_done
);

    localparam logic [4:0] c_max_coeff = 5'(MAX_COEFF);

    cavlc_state_e r_state, w_state_nxt;
    logic [4:0]   r_max_coeff, w_max_coeff_nxt;
    logic [4:0]   r_total_coeff, w_total_coeff_nxt;
    logic [1:0]   r_trailing_ones, w_trailing_ones_nxt;
    logic [3:0]   r_i_level, w_i_level_nxt;
    logic [3:0]   r_i_run, w_i_run_nxt;
    logic [3:0]   r_zeros_left, w_zeros_left_nxt;

    logic         w_to_tz;
    logic         w_tz_skip;
    logic         w_last_level;
    logic         w_last_run;
    logic [3:0]   w_zeros_sub;

    assign w_tz_skip    = (r_total_coeff == r_max_coeff);
    assign w_last_level = ({1'b0, r_i_level} == (r_total_coeff - 5'd1));
    // TotalCoeff-2 only means something once at least two coefficients exist.
    assign w_last_run   = (r_total_coeff >= 5'd2) &&
                          ({1'b0, r_i_run} == (r_total_coeff - 5'd2));
    assign w_zeros_sub  = sat_sub4(r_zeros_left, run_before_lut);

    always_comb begin
        w_state_nxt         = r_state;
        w_max_coeff_nxt     = r_max_coeff;
        w_total_coeff_nxt   = r_total_coeff;
        w_trailing_ones_nxt = r_trailing_ones;
        w_i_level_nxt       = r_i_level;
        w_i_run_nxt         = r_i_run;
        w_zeros_left_nxt    = r_zeros_left;
        w_to_tz             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cavlc_start) begin
                    w_max_coeff_nxt = (maxNumCoeff > c_max_coeff) ? c_max_coeff : maxNumCoeff;
                    w_state_nxt     = ST_NC_T1_LUT;
                end
            end
            ST_NC_T1_LUT: begin
                if (bs_ready) begin
                    w_total_coeff_nxt   = TotalCoeff_lut;
                    w_trailing_ones_nxt = TrailingOnes_lut;
                    w_i_level_nxt       = 4'd0;
                    if (TotalCoeff_lut == 5'd0)
                        w_state_nxt = ST_DONE;
                    else if (TrailingOnes_lut != 2'd0)
                        w_state_nxt = ST_T1_SIGN;
                    else
                        w_state_nxt = ST_LEVEL_PREFIX;
                end
            end
            ST_T1_SIGN: begin
                if (bs_ready) begin
                    w_i_level_nxt = {2'b00, r_trailing_ones};
                    if ({3'b000, r_trailing_ones} == r_total_coeff)
                        w_to_tz = 1'b1;
                    else
                        w_state_nxt = ST_LEVEL_PREFIX;
                end
            end
            ST_LEVEL_PREFIX: begin
                if (bs_ready)
                    w_state_nxt = ST_LEVEL_SUFFIX;
            end
            ST_LEVEL_SUFFIX: begin
                if (bs_ready) begin
                    if (w_last_level) begin
                        w_to_tz = 1'b1;
                    end else begin
                        w_i_level_nxt = r_i_level + 4'd1;
                        w_state_nxt   = ST_LEVEL_PREFIX;
                    end
                end
            end
            ST_TZ_LUT: begin
                if (bs_ready) begin
                    w_zeros_left_nxt = total_zeros_lut;
                    w_i_run_nxt      = 4'd0;
                    if ((total_zeros_lut == 4'd0) || (r_total_coeff == 5'd1))
                        w_state_nxt = ST_DONE;
                    else
                        w_state_nxt = ST_RB_LUT;
                end
            end
            ST_RB_LUT: begin
                if (bs_ready)
                    w_state_nxt = ST_RUN_ZEROS;
            end
            ST_RUN_ZEROS: begin
                if (bs_ready) begin
                    w_zeros_left_nxt = w_zeros_sub;
                    if ((w_zeros_sub == 4'd0) || w_last_run) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_i_run_nxt = r_i_run + 4'd1;
                        w_state_nxt = ST_RB_LUT;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A full block (TotalCoeff==maxNumCoeff) has no zeros, so its LUT is skipped.
        if (w_to_tz) begin
            if (w_tz_skip) begin
                w_zeros_left_nxt = 4'd0;
                w_state_nxt      = ST_DONE;
            end else begin
                w_state_nxt = ST_TZ_LUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_max_coeff     <= 5'd0;
            r_total_coeff   <= 5'd0;
            r_trailing_ones <= 2'd0;
            r_i_level       <= 4'd0;
            r_i_run         <= 4'd0;
            r_zeros_left    <= 4'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_max_coeff     <= w_max_coeff_nxt;
            r_total_coeff   <= w_total_coeff_nxt;
            r_trailing_ones <= w_trailing_ones_nxt;
            r_i_level       <= w_i_level_nxt;
            r_i_run         <= w_i_run_nxt;
            r_zeros_left    <= w_zeros_left_nxt;
        end
    end

    assign cavlc_decoder_state = STATE_W'(r_state);
    assign TotalCoeff          = r_total_coeff;
    assign TrailingOnes        = r_trailing_ones;
    assign i_level             = r_i_level;
    assign i_run               = r_i_run;
    assign zerosLeft           = r_zeros_left;
    assign cavlc_done          = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cavlc_decoding_ctrl.sv
// ----------------------------------------------------------------------------
// | Module   : tb_cavlc_decoding_ctrl                                         |
// | Brief    : Vector table, random blocks vs reference model, corner cases   |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cavlc_decoding_ctrl;
    import cavlc_decoding_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cavlc_start;
    logic [4:0] maxNumCoeff;
    logic       bs_ready;
    logic [4:0] TotalCoeff_lut;
    logic [1:0] TrailingOnes_lut;
    logic [3:0] total_zeros_lut;
    logic [3:0] run_before_lut;
    logic [3:0] cavlc_decoder_state;
    logic [4:0] TotalCoeff;
    logic [1:0] TrailingOnes;
    logic [3:0] i_level;
    logic [3:0] i_run;
    logic [3:0] zerosLeft;
    logic       cavlc_done;

    cavlc_decoding_ctrl #(.STATE_W(4), .MAX_COEFF(16)) dut (
        .clk(clk), .reset_n(reset_n), .cavlc_start(cavlc_start), .maxNumCoeff(maxNumCoeff),
        .bs_ready(bs_ready), .TotalCoeff_lut(TotalCoeff_lut), .TrailingOnes_lut(TrailingOnes_lut),
        .total_zeros_lut(total_zeros_lut), .run_before_lut(run_before_lut),
        .cavlc_decoder_state(cavlc_decoder_state), .TotalCoeff(TotalCoeff),
        .TrailingOnes(TrailingOnes), .i_level(i_level), .i_run(i_run),
        .zerosLeft(zerosLeft), .cavlc_done(cavlc_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  tc;
        logic [1:0]  t1;
        logic [4:0]  mx;
        logic [3:0]  tz;
        logic [63:0] rb;
        int          lat;
        int          il;
        int          ir;
        int          zl;
    } vec_t;

    vec_t              vecs [11];
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [15:0][3:0]  cur_rb;
    logic [3:0]        exp_tr[$];
    logic [3:0]        act[$];
    int                ndone;
    int                m_tc, m_t1, m_il, m_ir, m_zl, m_lat;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference: expand a block's syntax elements into the visited-state list.
    task automatic model(input int tc, input int t1, input int mx, input int tz,
                         input logic [15:0][3:0] rb);
        int runs = 0;
        int tzl  = 0;
        exp_tr.delete();
        exp_tr.push_back(ST_NC_T1_LUT);
        m_tc = tc;
        m_t1 = t1;
        if (tc == 0) begin
            m_il = 0;
        end else begin
            if (t1 > 0) exp_tr.push_back(ST_T1_SIGN);
            for (int l = t1; l < tc; l++) begin
                exp_tr.push_back(ST_LEVEL_PREFIX);
                exp_tr.push_back(ST_LEVEL_SUFFIX);
            end
            m_il = (t1 == tc) ? t1 : tc - 1;
            if (tc == mx) begin
                m_zl = 0;
            end else begin
                exp_tr.push_back(ST_TZ_LUT);
                tzl  = 1;
                m_zl = tz;
                m_ir = 0;
                if (tz != 0 && tc != 1) begin
                    for (int r = 0; r < tc - 1; r++) begin
                        exp_tr.push_back(ST_RB_LUT);
                        exp_tr.push_back(ST_RUN_ZEROS);
                        runs++;
                        m_zl = (m_zl > int'(rb[r])) ? m_zl - int'(rb[r]) : 0;
                        m_ir = r;
                        if (m_zl == 0) break;
                    end
                end
            end
        end
        exp_tr.push_back(ST_DONE);
        m_lat = 1 + ((t1 > 0) ? 1 : 0) + 2 * (tc - t1) + tzl + 2 * runs + 1;
    endtask

    task automatic start_block(input logic [4:0] tc, input logic [1:0] t1, input logic [4:0] mx,
                               input logic [3:0] tz, input logic [63:0] rb);
        cur_rb           = rb;
        TotalCoeff_lut   = tc;
        TrailingOnes_lut = t1;
        maxNumCoeff      = mx;
        total_zeros_lut  = tz;
        run_before_lut   = cur_rb[0];
        bs_ready         = 1'b1;
        cavlc_start      = 1'b1;
        @(posedge clk); #1;
        cavlc_start      = 1'b0;
    endtask

    // Records each advancing cycle's state until idle; optional stalls and stray starts.
    task automatic run_until_idle(input bit stall, input bit noise);
        bit         fin = 1'b0;
        bit         bs;
        int         k   = 0;
        logic [3:0] st;
        act.delete();
        ndone = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            st = cavlc_decoder_state;
            if (st == ST_IDLE) begin
                fin = 1'b1;
            end else begin
                bs = !(stall && st != ST_DONE && $urandom_range(0, 3) == 0);
                bs_ready       = bs;
                run_before_lut = cur_rb[k];
                cavlc_start    = noise && ($urandom_range(0, 7) == 0);
                if (cavlc_done) ndone++;
                if (bs || st == ST_DONE) act.push_back(st);
                if (bs && st == ST_RUN_ZEROS && k < 15) k++;
                @(posedge clk); #1;
            end
        end
        cavlc_start = 1'b0;
        bs_ready    = 1'b1;
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: block still busy after 200 cycles, state %0d", st);
        end
    endtask

    task automatic check_block(input string tag, input int lat, input int il,
                               input int ir, input int zl);
        int bad = -1;
        int n   = (act.size() < exp_tr.size()) ? act.size() : exp_tr.size();
        for (int i = 0; i < n; i++)
            if (bad < 0 && act[i] !== exp_tr[i]) bad = i;
        if (bad < 0 && act.size() != exp_tr.size()) bad = n;
        check({tag, " trace_first_bad_idx"}, bad, -1);
        check({tag, " latency"}, act.size(), lat);
        check({tag, " done_pulses"}, ndone, 1);
        check({tag, " TotalCoeff"}, TotalCoeff, m_tc);
        check({tag, " TrailingOnes"}, TrailingOnes, m_t1);
        check({tag, " i_level"}, i_level, il);
        check({tag, " i_run"}, i_run, ir);
        check({tag, " zerosLeft"}, zerosLeft, zl);
    endtask

    initial begin
        logic [15:0][3:0] rbr;
        int tc, t1, mx, tz;

        vecs[0]  = '{5'd0,  2'd0, 5'd16, 4'd0, 64'h0,   2,  0,  0, 0};
        vecs[1]  = '{5'd3,  2'd1, 5'd16, 4'd2, 64'h11, 12,  2,  1, 0};
        vecs[2]  = '{5'd16, 2'd3, 5'd16, 4'd0, 64'h0,  29, 15,  1, 0};
        vecs[3]  = '{5'd4,  2'd0, 5'd16, 4'd5, 64'h5,  13,  3,  0, 0};
        vecs[4]  = '{5'd1,  2'd1, 5'd15, 4'd3, 64'h0,   4,  1,  0, 3};
        vecs[5]  = '{5'd4,  2'd0, 5'd4,  4'd0, 64'h0,  10,  3,  0, 0};
        vecs[6]  = '{5'd5,  2'd2, 5'd16, 4'd0, 64'h0,  10,  4,  0, 0};
        vecs[7]  = '{5'd3,  2'd0, 5'd15, 4'd6, 64'h12, 13,  2,  1, 3};
        vecs[8]  = '{5'd0,  2'd0, 5'd16, 4'd0, 64'h0,   2,  0,  1, 3};
        vecs[9]  = '{5'd2,  2'd0, 5'd16, 4'd2, 64'h7,   9,  1,  0, 0};
        vecs[10] = '{5'd3,  2'd3, 5'd16, 4'd1, 64'h1,   6,  3,  0, 0};

        reset_n = 1'b0; cavlc_start = 1'b0; maxNumCoeff = 5'd16; bs_ready = 1'b1;
        TotalCoeff_lut = '0; TrailingOnes_lut = '0; total_zeros_lut = '0; run_before_lut = '0;
        m_ir = 0; m_zl = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset state", cavlc_decoder_state, ST_IDLE);
        check("reset counters", {TotalCoeff, TrailingOnes, i_level, i_run, zerosLeft}, 0);
        check("reset done", cavlc_done, 0);

        for (int i = 0; i < 11; i++) begin
            model(vecs[i].tc, vecs[i].t1, vecs[i].mx, vecs[i].tz, vecs[i].rb);
            start_block(vecs[i].tc, vecs[i].t1, vecs[i].mx, vecs[i].tz, vecs[i].rb);
            run_until_idle(1'b0, 1'b0);
            check_block($sformatf("vec%0d", i), vecs[i].lat, vecs[i].il, vecs[i].ir, vecs[i].zl);
        end

        // Stall in LevelPrefix: nothing may move while bs_ready is low.
        model(2, 0, 16, 0, 64'h0);
        start_block(5'd2, 2'd0, 5'd16, 4'd0, 64'h0);
        @(posedge clk); #1;
        check("stall enter prefix", cavlc_decoder_state, ST_LEVEL_PREFIX);
        bs_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall hold", {cavlc_decoder_state, i_level, TotalCoeff},
                  {ST_LEVEL_PREFIX, 4'd0, 5'd2});
        end
        bs_ready = 1'b1;
        run_until_idle(1'b0, 1'b0);
        act.push_front(ST_NC_T1_LUT);
        check_block("stall", m_lat, m_il, m_ir, m_zl);

        // Start during the done cycle is dropped; the one after it is taken.
        model(0, 0, 16, 0, 64'h0);
        start_block(5'd0, 2'd0, 5'd16, 4'd0, 64'h0);
        @(posedge clk); #1;
        check("done pulse", cavlc_done, 1);
        cavlc_start = 1'b1;
        @(posedge clk); #1;
        check("start in done ignored", cavlc_decoder_state, ST_IDLE);
        @(posedge clk); #1;
        check("start after done taken", cavlc_decoder_state, ST_NC_T1_LUT);
        cavlc_start = 1'b0;
        run_until_idle(1'b0, 1'b0);
        check_block("restart", m_lat, m_il, m_ir, m_zl);

        // Asynchronous reset in RunOfZeros aborts without a done pulse.
        start_block(5'd3, 2'd0, 5'd16, 4'd4, 64'h11);
        for (int c = 0; c < 40 && cavlc_decoder_state != ST_RUN_ZEROS; c++) begin
            @(posedge clk); #1;
        end
        check("reach RunOfZeros", cavlc_decoder_state, ST_RUN_ZEROS);
        reset_n = 1'b0;
        #1;
        check("async reset state", cavlc_decoder_state, ST_IDLE);
        check("async reset counters", {TotalCoeff, TrailingOnes, i_level, i_run, zerosLeft}, 0);
        @(posedge clk); #1;
        check("no done in reset", cavlc_done, 0);
        reset_n = 1'b1;
        m_ir = 0; m_zl = 0;
        model(2, 1, 15, 3, 64'h2);
        start_block(5'd2, 2'd1, 5'd15, 4'd3, 64'h2);
        run_until_idle(1'b0, 1'b0);
        check_block("post reset", m_lat, m_il, m_ir, m_zl);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       mx = 4;
                1:       mx = 15;
                default: mx = 16;
            endcase
            tc = $urandom_range(0, mx);
            t1 = (tc == 0) ? 0 : $urandom_range(0, (tc < 3) ? tc : 3);
            tz = (tc == mx) ? 0 : $urandom_range(0, ((mx - tc) < 15) ? (mx - tc) : 15);
            for (int k = 0; k < 16; k++) rbr[k] = 4'($urandom_range(0, 7));
            model(tc, t1, mx, tz, rbr);
            start_block(5'(tc), 2'(t1), 5'(mx), 4'(tz), rbr);
            run_until_idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_block($sformatf("rnd%0d", n), m_lat, m_il, m_ir, m_zl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
